// File: rtl/snow64_seq_vector_mul_pkg.sv
// rtl/snow64_seq_vector_mul_pkg.sv - state encoding for the sequential vector multiplier
package snow64_seq_vector_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/snow64_sliced_data_pkg.sv
// rtl/snow64_sliced_data_pkg.sv - shared sliced-data lane types, lane sizes and lane counts
package snow64_sliced_data_pkg;

    typedef enum logic [1:0] {
        INT_TYPE_SZ_8  = 2'd0,
        INT_TYPE_SZ_16 = 2'd1,
        INT_TYPE_SZ_32 = 2'd2,
        INT_TYPE_SZ_64 = 2'd3
    } int_type_size_t;

    localparam int LANES_SZ_8  = 8;
    localparam int LANES_SZ_16 = 4;
    localparam int LANES_SZ_32 = 2;
    localparam int LANES_SZ_64 = 1;

    // Lane 0 sits at the LSBs in every view.
    typedef struct packed {
        logic [7:0][7:0] lanes;
    } sliced_data_8_t;

    typedef struct packed {
        logic [3:0][15:0] lanes;
    } sliced_data_16_t;

    typedef struct packed {
        logic [1:0][31:0] lanes;
    } sliced_data_32_t;

    typedef struct packed {
        logic [63:0] lane;
    } sliced_data_64_t;

    function automatic logic [2:0] last_lane_index(input int_type_size_t sz);
        case (sz)
            INT_TYPE_SZ_8:  return 3'(LANES_SZ_8 - 1);
            INT_TYPE_SZ_16: return 3'(LANES_SZ_16 - 1);
            INT_TYPE_SZ_32: return 3'(LANES_SZ_32 - 1);
            default:        return 3'(LANES_SZ_64 - 1);
        endcase
    endfunction

endpackage

// File: rtl/snow64_vector_lane_select.sv
// rtl/snow64_vector_lane_select.sv - picks one lane of a 64-bit sliced vector, zero-extended
//
// Ports:
//   vec   - 64-bit packed vector, lane 0 at LSBs
//   size  - lane size (8/16/32/64)
//   index - lane index; upper bits ignored for wider lanes
//   lane  - selected lane zero-extended to 64 bits
module snow64_vector_lane_select
    import snow64_sliced_data_pkg::*;
(
    input  logic [63:0]    vec,
    input  int_type_size_t size,
    input  logic [2:0]     index,
    output logic [63:0]    lane
);

    sliced_data_8_t  s8;
    sliced_data_16_t s16;
    sliced_data_32_t s32;
    sliced_data_64_t s64;

    assign s8  = vec;
    assign s16 = vec;
    assign s32 = vec;
    assign s64 = vec;

    always_comb begin
        lane = '0;
        case (size)
            INT_TYPE_SZ_8:  lane = {56'd0, s8.lanes[index]};
            INT_TYPE_SZ_16: lane = {48'd0, s16.lanes[index[1:0]]};
            INT_TYPE_SZ_32: lane = {32'd0, s32.lanes[index[0]]};
            default:        lane = s64.lane;
        endcase
    end

endmodule

// File: rtl/snow64_seq_vector_mul.sv
// rtl/snow64_seq_vector_mul.sv - multi-cycle SIMD integer multiplier, one lane per cycle
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   in_start         - start request, accepted in IDLE or DONE
//   in_int_type_size - lane size 0=8, 1=16, 2=32, 3=64 bits
//   in_a, in_b       - packed operand vectors
//   out_busy         - high while lanes are being computed
//   out_valid        - one-cycle pulse when out_data is complete
//   out_data         - truncated per-lane products
module snow64_seq_vector_mul
    import snow64_sliced_data_pkg::*;
    import snow64_seq_vector_mul_pkg::*;
#(
    parameter int WIDTH_DATA = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic [1:0]            in_int_type_size,
    input  logic [WIDTH_DATA-1:0] in_a,
    input  logic [WIDTH_DATA-1:0] in_b,
    output logic                  out_busy,
    output logic                  out_valid,
    output logic [WIDTH_DATA-1:0] out_data
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            last_lane;

    logic [63:0]     a_q;
    logic [63:0]     b_q;
    int_type_size_t  size_q;
    logic [2:0]      counter;
    logic [63:0]     result_q;

    logic [63:0]     lane_a;
    logic [63:0]     lane_b;
    logic [63:0]     prod;

    snow64_vector_lane_select u_sel_a (
        .vec   (a_q),
        .size  (size_q),
        .index (counter),
        .lane  (lane_a)
    );

    snow64_vector_lane_select u_sel_b (
        .vec   (b_q),
        .size  (size_q),
        .index (counter),
        .lane  (lane_b)
    );

    // Low 64 bits suffice: every lane keeps at most its own width of the product.
    assign prod      = lane_a * lane_b;
    assign last_lane = (counter == last_lane_index(size_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_lane) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back start skips IDLE so there is no bubble.
                if (in_start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result lanes are not cleared on accept: lanes not yet rewritten keep
    // their previous values until their turn comes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            size_q   <= INT_TYPE_SZ_8;
            counter  <= '0;
            result_q <= '0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            size_q  <= int_type_size_t'(in_int_type_size);
            counter <= '0;
        end else if (state == ST_RUN) begin
            case (size_q)
                INT_TYPE_SZ_8:  result_q[{counter, 3'b000} +: 8]       <= prod[7:0];
                INT_TYPE_SZ_16: result_q[{counter[1:0], 4'b0000} +: 16] <= prod[15:0];
                INT_TYPE_SZ_32: result_q[{counter[0], 5'b00000} +: 32]  <= prod[31:0];
                default:        result_q                                <= prod;
            endcase
            if (!last_lane) begin
                counter <= counter + 3'd1;
            end
        end
    end

    assign out_busy  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign out_data  = result_q;

endmodule

// File: tb/tb_snow64_seq_vector_mul.sv
// tb/tb_snow64_seq_vector_mul.sv - self-checking bench for snow64_seq_vector_mul
module tb_snow64_seq_vector_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic [1:0]  in_int_type_size = 2'd0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        out_busy;
    logic        out_valid;
    logic [63:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int TIMEOUT = 50;

    always #5 clk = ~clk;

    snow64_seq_vector_mul #(.WIDTH_DATA(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_start         (in_start),
        .in_int_type_size (in_int_type_size),
        .in_a             (in_a),
        .in_b             (in_b),
        .out_busy         (out_busy),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    // Reference: per-lane product modulo 2^width, lanes packed from the LSB.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sz);
        int          w = 8 << sz;
        int          n = 8 >> sz;
        logic [63:0] mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        logic [63:0] res = '0;
        for (int i = 0; i < n; i++) begin
            logic [63:0] la = (a >> (i * w)) & mask;
            logic [63:0] lb = (b >> (i * w)) & mask;
            logic [63:0] p  = la * lb;
            res = res | ((p & mask) << (i * w));
        end
        return res;
    endfunction

    function automatic int ref_lanes(input logic [1:0] sz);
        return 8 >> sz;
    endfunction

    // Waits (at negedges) for out_valid; reports busy cycles seen and whether
    // busy was ever low before valid.
    task automatic wait_valid(output int busy_cycles, output bit busy_gap, output bit timed_out);
        busy_cycles = 0;
        busy_gap    = 1'b0;
        timed_out   = 1'b0;
        while (!out_valid) begin
            if (busy_cycles >= TIMEOUT) begin
                timed_out = 1'b1;
                break;
            end
            if (!out_busy) busy_gap = 1'b1;
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    // Drives a one-cycle start at a negedge, returns at the negedge after the accepting edge.
    task automatic pulse_start(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sz);
        in_a = a;
        in_b = b;
        in_int_type_size = sz;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] sz);
        int busy_cycles;
        bit gap, to;
        logic [63:0] exp;
        exp = ref_mul(a, b, sz);
        pulse_start(a, b, sz);
        wait_valid(busy_cycles, gap, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, TIMEOUT);
            return;
        end
        if (busy_cycles !== ref_lanes(sz) || gap) begin
            n_fail++;
            $display("FAIL %s latency: got %0d busy cycles (gap=%0d), expected %0d", name,
                     busy_cycles, gap, ref_lanes(sz));
        end
        n_checks++;
        if (out_data !== exp || out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s data: got %h busy=%b, expected %h busy=0", name, out_data,
                     out_busy, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b valid=%b data=%h, expected 0/0/0", out_busy, out_valid,
                     out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0/0", out_busy, out_valid);
        end
    endtask

    task automatic test_directed();
        run_and_check("size8", 64'h0102030405060708, 64'h0202020202020202, 2'd0);
        n_checks++;
        if (64'h020406080A0C0E10 !== ref_mul(64'h0102030405060708, 64'h0202020202020202, 2'd0)
            || out_data !== 64'h020406080A0C0E10) begin
            n_fail++;
            $display("FAIL size8_const: got %h, expected 020406080a0c0e10", out_data);
        end
        @(negedge clk);
        run_and_check("size16", 64'hFFFF000301000002, 64'h0002000501000003, 2'd1);
        n_checks++;
        if (out_data !== 64'hFFFE000F00000006) begin
            n_fail++;
            $display("FAIL size16_const: got %h, expected fffe000f00000006", out_data);
        end
        // Result must hold through DONE->IDLE.
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_data !== 64'hFFFE000F00000006 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_done: got %h valid=%b, expected fffe000f00000006 valid=0",
                     out_data, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cycles;
        bit gap, to;
        run_and_check("b2b_size32", 64'h0000001080000000, 64'h0000001000000002, 2'd2);
        n_checks++;
        if (out_data !== 64'h0000010000000000) begin
            n_fail++;
            $display("FAIL b2b_size32_const: got %h, expected 0000010000000000", out_data);
        end
        // Currently in DONE: start again immediately.
        pulse_start(64'd3, 64'd5, 2'd3);
        n_checks++;
        if (out_valid !== 1'b0 || out_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: valid=%b busy=%b, expected 0/1", out_valid, out_busy);
        end
        wait_valid(busy_cycles, gap, to);
        n_checks++;
        if (to || busy_cycles !== 1 || out_data !== 64'h000000000000000F) begin
            n_fail++;
            $display("FAIL b2b_size64: timeout=%0d cycles=%0d data=%h, expected 1 cycle data f",
                     to, busy_cycles, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int valids;
        logic [63:0] a, b, first_data;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        first_data = 64'd0;
        pulse_start(a, b, 2'd0);
        @(negedge clk);
        @(negedge clk);
        in_a = ~a;
        in_b = b + 64'd1;
        in_int_type_size = 2'd3;
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                if (valids == 0) first_data = out_data;
                valids++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (valids !== 1) begin
            n_fail++;
            $display("FAIL start_ignored_count: got %0d valid pulses, expected 1", valids);
        end
        n_checks++;
        if (first_data !== ref_mul(a, b, 2'd0)) begin
            n_fail++;
            $display("FAIL start_ignored_data: got %h, expected %h", first_data,
                     ref_mul(a, b, 2'd0));
        end
    endtask

    task automatic test_reset_mid_op();
        int valids;
        pulse_start(64'h1111111111111111, 64'h0303030303030303, 2'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b valid=%b data=%h, expected 0/0/0", out_busy,
                     out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valids = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid || out_busy) valids++;
            @(negedge clk);
        end
        n_checks++;
        if (valids !== 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: got %0d active cycles after reset, expected 0", valids);
        end
        run_and_check("after_reset", {$urandom, $urandom}, {$urandom, $urandom}, 2'd0);
        @(negedge clk);
    endtask

    task automatic test_size_change();
        int busy_cycles;
        bit gap, to;
        logic [63:0] a, b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        pulse_start(a, b, 2'd1);
        in_int_type_size = 2'd0;
        wait_valid(busy_cycles, gap, to);
        n_checks++;
        if (to || busy_cycles !== 4 || out_data !== ref_mul(a, b, 2'd1)) begin
            n_fail++;
            $display("FAIL size_change: timeout=%0d cycles=%0d data=%h, expected 4 cycles data %h",
                     to, busy_cycles, out_data, ref_mul(a, b, 2'd1));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            run_and_check($sformatf("random%0d_sz%0d", i, sz), {$urandom, $urandom},
                          {$urandom, $urandom}, sz);
            // Alternate between back-to-back and idle gaps.
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_op();
        test_size_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
